// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes four BCD digits onto one active-low 7-segment
// bus, with dead-time between digits, leading-zero blanking and frame snapshots.
module seg_scan_ctrl #(
   parameter int HOLD_TICKS  = 4,
   parameter int BLANK_TICKS = 1
) (
   input  logic        mclk,
   input  logic        rst,
   input  logic        tick,
   input  logic        en,
   input  logic        lzb_en,
   input  logic [15:0] bcd_in,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  digit_idx,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);
   localparam logic [7:0] BLANK_LAST = (BLANK_TICKS > 0) ? 8'(BLANK_TICKS - 1) : 8'd0;
   localparam bit         HAS_BLANK  = (BLANK_TICKS > 0);

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] bcd_snap_q, bcd_snap_d;
   logic [3:0]  dp_snap_q, dp_snap_d;
   logic        frame_d;
   logic [3:0]  an_d;
   logic [6:0]  seg_d;
   logic        dp_d;
   logic        z3, z32, z321, lz_blank;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h7F;
      endcase
   endfunction

   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      bcd_snap_d = bcd_snap_q;
      dp_snap_d  = dp_snap_q;
      frame_d    = 1'b0;
      if (!en) begin
         state_d = IDLE;
         idx_d   = 2'd0;
         cnt_d   = 8'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d    = DRIVE;
               idx_d      = 2'd0;
               cnt_d      = 8'd0;
               bcd_snap_d = bcd_in;
               dp_snap_d  = dp_in;
            end
            DRIVE: if (tick) begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d = 8'd0;
                  if (HAS_BLANK) begin
                     state_d = BLANK;
                  end else begin
                     idx_d   = idx_q + 2'd1;
                     frame_d = (idx_q == 2'd3);
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            BLANK: if (tick) begin
               if (cnt_q == BLANK_LAST) begin
                  cnt_d   = 8'd0;
                  state_d = DRIVE;
                  idx_d   = idx_q + 2'd1;
                  frame_d = (idx_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: state_d = IDLE;
         endcase
         // A new frame starts from a fresh, coherent copy of the display value.
         if (frame_d) begin
            bcd_snap_d = bcd_in;
            dp_snap_d  = dp_in;
         end
      end
   end

   // Outputs are decoded from next-state values so they register on the same edge.
   always_comb begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      z3    = (bcd_snap_d[15:12] == 4'd0);
      z32   = z3 && (bcd_snap_d[11:8] == 4'd0);
      z321  = z32 && (bcd_snap_d[7:4] == 4'd0);
      case (idx_d)
         2'd3:    lz_blank = z3;
         2'd2:    lz_blank = z32;
         2'd1:    lz_blank = z321;
         default: lz_blank = 1'b0;
      endcase
      if (state_d == DRIVE) begin
         an_d[idx_d] = 1'b0;
         dp_d        = ~dp_snap_d[idx_d];
         if (!(lzb_en && lz_blank)) seg_d = decode(bcd_snap_d[{idx_d, 2'b00} +: 4]);
      end
   end

   // NOTE: non-blocking assignments make every register update from pre-edge values.
   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= 2'd0;
         cnt_q      <= 8'd0;
         bcd_snap_q <= 16'd0;
         dp_snap_q  <= 4'd0;
         an         <= 4'hF;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         bcd_snap_q <= bcd_snap_d;
         dp_snap_q  <= dp_snap_d;
         an         <= an_d;
         seg        <= seg_d;
         dp         <= dp_d;
         frame_done <= frame_d;
      end
   end

   assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed, table-driven checks of the display scanner with
// and without blanking dead-time.
module tb_seg_scan_ctrl;

   logic        mclk   = 1'b0;
   logic        rst    = 1'b1;
   logic        tick   = 1'b0;
   logic        en     = 1'b0;
   logic        lzb_en = 1'b0;
   logic [15:0] bcd_in = 16'h0;
   logic [3:0]  dp_in  = 4'h0;

   logic [3:0] an, an_nb;
   logic [6:0] seg, seg_nb;
   logic       dp, dp_nb;
   logic [1:0] digit_idx, digit_idx_nb;
   logic       frame_done, frame_done_nb;

   always #5 mclk = ~mclk;

   seg_scan_ctrl #(.HOLD_TICKS(4), .BLANK_TICKS(1)) dut (
      .mclk(mclk), .rst(rst), .tick(tick), .en(en), .lzb_en(lzb_en),
      .bcd_in(bcd_in), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp),
      .digit_idx(digit_idx), .frame_done(frame_done)
   );

   seg_scan_ctrl #(.HOLD_TICKS(2), .BLANK_TICKS(0)) dut_nb (
      .mclk(mclk), .rst(rst), .tick(tick), .en(en), .lzb_en(lzb_en),
      .bcd_in(bcd_in), .dp_in(dp_in), .an(an_nb), .seg(seg_nb), .dp(dp_nb),
      .digit_idx(digit_idx_nb), .frame_done(frame_done_nb)
   );

   typedef struct {
      int          gap;   // idle cycles before the tick
      logic [14:0] exp;   // {an, seg, dp, digit_idx, frame_done}
   } vec_t;

   localparam logic [14:0] OFF = {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};

   int n_cmp    = 0;
   int n_bad    = 0;
   int fd_count = 0;

   always @(negedge mclk) if (frame_done === 1'b1) fd_count++;

   function automatic logic [14:0] pk(input logic [3:0] a, input logic [6:0] s,
                                      input logic d, input logic [1:0] i, input logic f);
      return {a, s, d, i, f};
   endfunction

   function automatic logic [14:0] got();
      return {an, seg, dp, digit_idx, frame_done};
   endfunction

   function automatic logic [14:0] got_nb();
      return {an_nb, seg_nb, dp_nb, digit_idx_nb, frame_done_nb};
   endfunction

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got an=%h seg=%h dp=%b idx=%0d fd=%b, expected an=%h seg=%h dp=%b idx=%0d fd=%b",
                  name, act[14:11], act[10:4], act[3], act[2:1], act[0],
                  exp[14:11], exp[10:4], exp[3], exp[2:1], exp[0]);
      end
   endtask

   task automatic check_n(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge mclk);
      #1;
   endtask

   task automatic pulse(input int gap);
      repeat (gap) cycle();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) pulse(2);
   endtask

   task automatic start();
      en  = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      en  = 1'b1;
      cycle();
   endtask

   logic [3:0]  an_of    [4];
   logic [6:0]  seg_1234 [4];
   vec_t        basic_vec[20];
   vec_t        nb_vec   [8];
   logic [14:0] prev;
   int          fd_base;

   initial begin
      an_of    = '{4'hE, 4'hD, 4'hB, 4'h7};
      seg_1234 = '{7'h19, 7'h30, 7'h24, 7'h79};

      // Per digit: three ticks held, fourth tick blanks, fifth tick moves on.
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < 5; k++) begin
            basic_vec[d*5+k].gap = 9;
            if (k < 3)
               basic_vec[d*5+k].exp = pk(an_of[d], seg_1234[d], 1'b1, 2'(d), 1'b0);
            else if (k == 3)
               basic_vec[d*5+k].exp = pk(4'hF, 7'h7F, 1'b1, 2'(d), 1'b0);
            else
               basic_vec[d*5+k].exp = pk(an_of[(d+1)%4], seg_1234[(d+1)%4], 1'b1,
                                         2'((d+1)%4), d == 3);
         end
      end
      // HOLD=2, no blank: after tick t the bus belongs to digit t/2.
      for (int t = 1; t <= 8; t++) begin
         nb_vec[t-1].gap = 2;
         nb_vec[t-1].exp = pk(an_of[(t/2)%4], seg_1234[(t/2)%4], 1'b1, 2'((t/2)%4), t == 8);
      end

      // Reset held for three cycles with tick active.
      rst  = 1'b1;
      tick = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("reset", got(), OFF);
      end
      check("reset_nb", got_nb(), OFF);
      rst  = 1'b0;
      tick = 1'b0;
      cycle();
      check("post_reset", got(), OFF);

      // Basic scan of 1234; the tick on the entry edge must not count.
      bcd_in = 16'h1234;
      dp_in  = 4'h0;
      en     = 1'b1;
      tick   = 1'b1;
      cycle();
      tick   = 1'b0;
      prev   = pk(4'hE, 7'h19, 1'b1, 2'd0, 1'b0);
      check("entry", got(), prev);
      fd_base = fd_count;
      for (int f = 0; f < 2; f++) begin
         foreach (basic_vec[v]) begin
            repeat (basic_vec[v].gap) cycle();
            check("hold", got(), {prev[14:1], 1'b0});
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            check("scan", got(), basic_vec[v].exp);
            prev = basic_vec[v].exp;
         end
         cycle();
         check("frame_done_clear", got(), {prev[14:1], 1'b0});
         check_n("frame_done_count", fd_count - fd_base, f + 1);
      end

      // Leading-zero blanking and invalid codes.
      lzb_en = 1'b1;
      bcd_in = 16'h0070;
      dp_in  = 4'b1000;
      start();
      check("lzb_d0", got(), pk(4'hE, 7'h40, 1'b1, 2'd0, 1'b0));
      ticks(5);
      check("lzb_d1", got(), pk(4'hD, 7'h78, 1'b1, 2'd1, 1'b0));
      ticks(5);
      check("lzb_d2", got(), pk(4'hB, 7'h7F, 1'b1, 2'd2, 1'b0));
      ticks(5);
      check("lzb_d3", got(), pk(4'h7, 7'h7F, 1'b0, 2'd3, 1'b0));
      bcd_in = 16'h000A;
      ticks(5);
      check("invalid_d0", got(), pk(4'hE, 7'h7F, 1'b1, 2'd0, 1'b1));
      lzb_en = 1'b0;

      // Snapshot coherence: a change while digit 1 is driven waits for the next frame.
      bcd_in = 16'h1234;
      dp_in  = 4'h0;
      start();
      ticks(5);
      check("snap_d1", got(), pk(4'hD, 7'h30, 1'b1, 2'd1, 1'b0));
      bcd_in = 16'h9999;
      ticks(5);
      check("snap_d2_old", got(), pk(4'hB, 7'h24, 1'b1, 2'd2, 1'b0));
      ticks(5);
      check("snap_d3_old", got(), pk(4'h7, 7'h79, 1'b1, 2'd3, 1'b0));
      for (int d = 0; d < 4; d++) begin
         ticks(5);
         check("snap_new", got(), pk(an_of[d], 7'h10, 1'b1, 2'(d), d == 0));
      end

      // No dead-time with BLANK_TICKS=0.
      bcd_in = 16'h1234;
      start();
      check("nb_entry", got_nb(), pk(4'hE, 7'h19, 1'b1, 2'd0, 1'b0));
      foreach (nb_vec[v]) begin
         pulse(nb_vec[v].gap);
         check("nb_scan", got_nb(), nb_vec[v].exp);
      end

      // Drop en mid-DRIVE on digit 2, then re-enable for a full hold on digit 0.
      ticks(3);
      check("mid_d2", got(), pk(4'hB, 7'h24, 1'b1, 2'd2, 1'b0));
      en = 1'b0;
      cycle();
      check("en_drop", got(), OFF);
      check("en_drop_nb", got_nb(), OFF);
      en = 1'b1;
      cycle();
      check("reenable", got(), pk(4'hE, 7'h19, 1'b1, 2'd0, 1'b0));
      for (int i = 0; i < 3; i++) begin
         ticks(1);
         check("reenable_hold", got(), pk(4'hE, 7'h19, 1'b1, 2'd0, 1'b0));
      end
      ticks(1);
      check("reenable_blank", got(), pk(4'hF, 7'h7F, 1'b1, 2'd0, 1'b0));

      // Reset in the BLANK after digit 1.
      start();
      ticks(9);
      check("blank_d1", got(), pk(4'hF, 7'h7F, 1'b1, 2'd1, 1'b0));
      rst = 1'b1;
      cycle();
      check("rst_mid_blank", got(), OFF);
      rst = 1'b0;
      cycle();
      check("restart_d0", got(), pk(4'hE, 7'h19, 1'b1, 2'd0, 1'b0));
      ticks(4);
      check("restart_blank0", got(), pk(4'hF, 7'h7F, 1'b1, 2'd0, 1'b0));
      ticks(1);
      check("restart_d1", got(), pk(4'hD, 7'h30, 1'b1, 2'd1, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
